// File: rtl/rv32i_pkg.sv
// rv32i_pkg: load/store op encodings, LSU state type and wait-counter width shared with the controller.
package rv32i_pkg;
  localparam logic [4:0] OP_LB  = 5'b01010;
  localparam logic [4:0] OP_LH  = 5'b01011;
  localparam logic [4:0] OP_LW  = 5'b01100;
  localparam logic [4:0] OP_LBU = 5'b01101;
  localparam logic [4:0] OP_LHU = 5'b01110;
  localparam logic [4:0] OP_SB  = 5'b01111;
  localparam logic [4:0] OP_SH  = 5'b10000;
  localparam logic [4:0] OP_SW  = 5'b10001;
  localparam int CNT_W = $clog2(256);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} lsu_state_t;
  function automatic logic is_load(input logic [4:0] op);
    return op >= OP_LB && op <= OP_LHU;
  endfunction
  function automatic logic op_bad(input logic [4:0] op, input logic [1:0] off);
    return op < OP_LB || op > OP_SW
        || ((op == OP_LH || op == OP_LHU || op == OP_SH) && off[0])
        || ((op == OP_LW || op == OP_SW) && off != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory req/ack port; master is the LSU, slave is the memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
  modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [4:0]  i_st_op,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [4:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_half = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
    o_load_data = i_ld_op == OP_LB  ? {{24{w_byte[7]}}, w_byte}
                : i_ld_op == OP_LBU ? {24'h0, w_byte}
                : i_ld_op == OP_LH  ? {{16{w_half[15]}}, w_half}
                : i_ld_op == OP_LHU ? {16'h0, w_half}
                : i_rdata;
    o_be = i_st_op == OP_SB ? 4'b0001 << i_st_off
         : i_st_op == OP_SH ? 4'b0011 << {i_st_off[1], 1'b0}
         : 4'b1111;
    o_wdata = i_st_op == OP_SB ? {4{i_store_data[7:0]}}
            : i_st_op == OP_SH ? {2{i_store_data[15:0]}}
            : i_store_data;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM; one req/ack memory access per start, with alignment,
// extension, misalignment/illegal-op rejection and a bus wait timeout.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         lsu_op,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  load_store_unit_if.master  mem,
  output logic [31:0]        load_data,
  output logic               done,
  output logic               err,
  output logic               busy
);
  lsu_state_t       r_state, w_next;
  logic [4:0]       r_op;
  logic [1:0]       r_off;
  logic [31:0]      r_addr, r_wdata, r_load;
  logic [3:0]       r_be;
  logic             r_we, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bad, w_to;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld;
  lsu_align u_align (
    .i_st_op(lsu_op), .i_st_off(addr[1:0]), .i_store_data(store_data),
    .o_be(w_be), .o_wdata(w_wdata),
    .i_ld_op(r_op), .i_ld_off(r_off), .i_rdata(mem.mem_rdata),
    .o_load_data(w_ld)
  );
  assign w_bad = op_bad(lsu_op, addr[1:0]);
  // ack in the final wait cycle wins over the timeout
  assign w_to  = !mem.mem_ack && r_cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_bad ? S_DONE : S_ACCESS;
      S_ACCESS: if (mem.mem_ack || w_to) w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_load  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op    <= lsu_op;
        r_off   <= addr[1:0];
        r_addr  <= {addr[31:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_we    <= !is_load(lsu_op);
        r_err   <= w_bad;
        r_cnt   <= '0;
        if (w_bad) r_load <= '0;
      end else if (r_state == S_ACCESS) begin
        if (mem.mem_ack) begin
          r_err <= 1'b0;
          if (is_load(r_op)) r_load <= w_ld;
        end else if (w_to) begin
          r_err  <= 1'b1;
          r_load <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
  assign mem.mem_req   = r_state == S_ACCESS;
  assign mem.mem_we    = mem.mem_req & r_we;
  assign mem.mem_be    = mem.mem_req ? r_be : 4'b0000;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign done          = r_state == S_DONE;
  assign err           = done & r_err;
  assign busy          = r_state != S_IDLE;
  assign load_data     = r_load;
endmodule
